spart_rx_param: RTL and testbench

Parametrised successor to the SPART serial receiver. Supports configurable data width, a run-time parity mode, and one or two stop bits. Adds an input synchroniser, a valid/ready output handshake with a one-entry holding register, and framing, parity and overrun error reporting. It sits between the rxd pad and the SPART control/bus-interface receive buffer, and uses the same divisor_buffer baud setting as the transmitter.

---
 rtl/spart_rx_param.sv | 256 +++++++++++++++++++++++++
 tb/tb_spart_rx_param.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_rx_param.sv
// spart_rx_param: parametrised SPART serial receiver.
// Receives LSB-first frames on rxd (start, DATA_BITS data, optional parity,
// STOP_BITS stop bits) using the shared divisor_buffer baud setting, and
// presents each word through a valid/ready holding register together with
// framing, parity and sticky overrun status.
// Optional build macro: SPART_RX_MAJORITY_EN -- when defined, every sample
// point takes the 2-of-3 majority of rxd_s around the point; frame timing is
// unchanged.
module spart_rx_param #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic [DIV_W-1:0]     divisor_buffer,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_ready,
    input  logic                 overrun_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int unsigned BCW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    // Synchroniser and sampling
    logic                 rxd_meta_q;
    logic                 rxd_s_q;
    logic                 sample_bit;

    // Frame FSM state
    state_t               state_q;
    logic [DIV_W-1:0]     cnt_q;
    logic [DIV_W-1:0]     div_q;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic [BCW-1:0]       bit_cnt_q;
    logic                 stop_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_q;
    logic                 ferr_q;

    // Output holding register
    logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
    logic                 rx_valid_q,   rx_valid_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q,    overrun_d;

    // Derived timing and delivery controls
    logic [DIV_W-1:0]     div_clamped;
    logic [DIV_W-1:0]     mid_cnt;
    logic                 tick;
    logic                 last_stop;
    logic                 deliver_ok;
    logic                 frame_drop;
    logic                 ferr_final;

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

`ifdef SPART_RX_MAJORITY_EN
    logic rxd_d1_q;

    // One-cycle history of rxd_s for the point-1 vote
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_d1_q <= 1'b1;
        end else begin
            rxd_d1_q <= rxd_s_q;
        end
    end

    // The point+1 vote is taken from the first synchroniser stage, which holds
    // next cycle's rxd_s, so the sample point itself does not move.
    always_comb begin
        sample_bit = (rxd_d1_q & rxd_s_q) | (rxd_s_q & rxd_meta_q) | (rxd_d1_q & rxd_meta_q);
    end
`else
    // Single sample at the sample point
    always_comb begin
        sample_bit = rxd_s_q;
    end
`endif

    // Divisor clamp, half-period load value and frame-end delivery decision
    always_comb begin
        div_clamped = (divisor_buffer < DIV_W'(3)) ? DIV_W'(3) : divisor_buffer;
        mid_cnt     = div_clamped >> 1;
        tick        = (cnt_q == '0);
        last_stop   = (state_q == STOP) && tick && (stop_cnt_q == 1'(STOP_BITS - 1));
        deliver_ok  = last_stop && (!rx_valid_q || rx_ready);
        frame_drop  = last_stop && rx_valid_q && !rx_ready;
        ferr_final  = ferr_q | ~sample_bit;
    end

    // Frame FSM: start qualification, data/parity/stop sampling, break wait
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rxd_s_q) begin
                        div_q      <= div_clamped;
                        par_en_q   <= parity_en;
                        par_odd_q  <= parity_odd;
                        cnt_q      <= mid_cnt;
                        bit_cnt_q  <= '0;
                        stop_cnt_q <= 1'b0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sample_bit) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= div_q;
                            state_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= {sample_bit, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= div_q;
                        if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                            state_q <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                PARITY: begin
                    if (tick) begin
                        perr_q  <= (((^shift_q) ^ sample_bit) != par_odd_q);
                        cnt_q   <= div_q;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                STOP: begin
                    if (tick) begin
                        cnt_q <= div_q;
                        if (!sample_bit) begin
                            ferr_q <= 1'b1;
                        end
                        if (last_stop) begin
                            state_q <= sample_bit ? IDLE : BREAK;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                BREAK: begin
                    if (rxd_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Holding register next state: load on delivery, clear on handshake,
    // sticky overrun with set winning over clear
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        if (deliver_ok) begin
            rx_data_d    = shift_q;
            rx_valid_d   = 1'b1;
            frame_err_d  = ferr_final;
            parity_err_d = perr_q;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d   = 1'b0;
            frame_err_d  = 1'b0;
            parity_err_d = 1'b0;
        end
        if (frame_drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // Holding register state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_spart_rx_param.sv
// Directed self-checking bench for spart_rx_param (DATA_BITS=8, STOP_BITS=1).
module tb_spart_rx_param;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;
    localparam int unsigned DIV_W     = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 rxd = 1'b1;
    logic [DIV_W-1:0]     divisor_buffer = 16'd9;
    logic                 parity_en = 1'b0;
    logic                 parity_odd = 1'b0;
    logic                 rx_ready = 1'b1;
    logic                 overrun_clr = 1'b0;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    always #5 clk = ~clk;

    spart_rx_param #(
        .DATA_BITS(DATA_BITS),
        .STOP_BITS(STOP_BITS),
        .DIV_W(DIV_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .divisor_buffer(divisor_buffer),
        .parity_en(parity_en),
        .parity_odd(parity_odd),
        .rx_ready(rx_ready),
        .overrun_clr(overrun_clr),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .overrun(overrun)
    );

    int tests = 0;
    int fails = 0;

    // Posedge counter and negedge capture of delivered words
    int cyc = 0;
    int frame_start_cyc = 0;
    int valid_cycles = 0;
    int first_valid_cyc = -1;
    logic [7:0] cap_data = '0;
    logic cap_ferr = 1'b0;
    logic cap_perr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            valid_cycles = valid_cycles + 1;
            cap_data = rx_data;
            cap_ferr = frame_err;
            cap_perr = parity_err;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic clear_mon();
        valid_cycles = 0;
        first_valid_cyc = -1;
        cap_data = '0;
        cap_ferr = 1'b0;
        cap_perr = 1'b0;
    endtask

    task automatic idle(input int k);
        rxd = 1'b1;
        repeat (k) @(negedge clk);
    endtask

    // Drives n bits of 'bits' LSB first, each held p cycles; called at a negedge
    task automatic send_raw(input logic [15:0] bits, input int n, input int p);
        for (int i = 0; i < n; i++) begin
            rxd = bits[i];
            if (i == 0) frame_start_cyc = cyc;
            repeat (p) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stopv, input int p);
        logic [15:0] bits;
        int n;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        n = 9;
        if (pen) begin
            bits[9] = pbit;
            n = 10;
        end
        bits[n] = stopv;
        n = n + 1;
        send_raw(bits, n, p);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", rx_valid); end
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", rx_data); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        tests++; if (parity_err !== 1'b0) begin fails++; $display("FAIL reset_perr got %b want 0", parity_err); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
        rst = 1'b1;
        idle(5);
    endtask

    task automatic test_basic();
        divisor_buffer = 16'd9;
        parity_en = 1'b0;
        rx_ready = 1'b1;
        clear_mon();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 10);
        idle(10);
        tests++; if (valid_cycles != 1) begin fails++; $display("FAIL basic_pulse got %0d valid cycles want 1", valid_cycles); end
        tests++; if (cap_data !== 8'hA5) begin fails++; $display("FAIL basic_data got %h want a5", cap_data); end
        tests++; if (cap_ferr !== 1'b0) begin fails++; $display("FAIL basic_ferr got %b want 0", cap_ferr); end
        tests++; if (cap_perr !== 1'b0) begin fails++; $display("FAIL basic_perr got %b want 0", cap_perr); end
        // 2 sync + 1 detect + 5 to start mid + 9 bit periods of 10, seen at next negedge
        tests++; if (first_valid_cyc - frame_start_cyc != 98) begin fails++; $display("FAIL basic_latency got %0d want 98", first_valid_cyc - frame_start_cyc); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_clear got %b want 0", rx_valid); end
    endtask

    task automatic test_parity();
        parity_en = 1'b1;
        parity_odd = 1'b0;
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 10);
        idle(10);
        tests++; if (cap_data !== 8'h07) begin fails++; $display("FAIL par_even_bad_data got %h want 07", cap_data); end
        tests++; if (cap_perr !== 1'b1) begin fails++; $display("FAIL par_even_bad_perr got %b want 1", cap_perr); end
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 10);
        idle(10);
        tests++; if (valid_cycles != 1) begin fails++; $display("FAIL par_even_ok_pulse got %0d want 1", valid_cycles); end
        tests++; if (cap_perr !== 1'b0) begin fails++; $display("FAIL par_even_ok_perr got %b want 0", cap_perr); end
        parity_odd = 1'b1;
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 10);
        idle(10);
        tests++; if (cap_perr !== 1'b1) begin fails++; $display("FAIL par_odd_bad_perr got %b want 1", cap_perr); end
        tests++; if (cap_ferr !== 1'b0) begin fails++; $display("FAIL par_odd_ferr got %b want 0", cap_ferr); end
        parity_en = 1'b0;
        parity_odd = 1'b0;
    endtask

    task automatic test_framing();
        clear_mon();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 10);
        repeat (30) @(negedge clk);
        tests++; if (valid_cycles != 1) begin fails++; $display("FAIL frame_pulse got %0d want 1", valid_cycles); end
        tests++; if (cap_data !== 8'h3C) begin fails++; $display("FAIL frame_data got %h want 3c", cap_data); end
        tests++; if (cap_ferr !== 1'b1) begin fails++; $display("FAIL frame_ferr got %b want 1", cap_ferr); end
        tests++; if (cap_perr !== 1'b0) begin fails++; $display("FAIL frame_perr got %b want 0", cap_perr); end
        idle(40);
        tests++; if (valid_cycles != 1) begin fails++; $display("FAIL break_spurious got %0d valid cycles want 1", valid_cycles); end
        clear_mon();
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 10);
        idle(10);
        tests++; if (cap_data !== 8'h96) begin fails++; $display("FAIL after_break_data got %h want 96", cap_data); end
        tests++; if (cap_ferr !== 1'b0) begin fails++; $display("FAIL after_break_ferr got %b want 0", cap_ferr); end
    endtask

    task automatic test_back_to_back_overrun();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 10);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 10);
        idle(10);
        tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid got %b want 1", rx_valid); end
        tests++; if (rx_data !== 8'h11) begin fails++; $display("FAIL ovr_data got %h want 11", rx_data); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set got %b want 1", overrun); end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b want 0", overrun); end
        tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL ovr_hold_valid got %b want 1", rx_valid); end
        rx_ready = 1'b1;
        @(negedge clk);
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL ovr_accept got %b want 0", rx_valid); end
        idle(5);
    endtask

    task automatic test_glitch();
        clear_mon();
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        idle(30);
        tests++; if (valid_cycles != 0) begin fails++; $display("FAIL glitch_pulse got %0d want 0", valid_cycles); end
        clear_mon();
        send_frame(8'h3A, 1'b0, 1'b0, 1'b1, 10);
        idle(10);
        tests++; if (valid_cycles != 1) begin fails++; $display("FAIL glitch_next_pulse got %0d want 1", valid_cycles); end
        tests++; if (cap_data !== 8'h3A) begin fails++; $display("FAIL glitch_next_data got %h want 3a", cap_data); end
    endtask

    task automatic test_clamp();
        divisor_buffer = 16'd1;
        clear_mon();
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 4);
        idle(10);
        tests++; if (valid_cycles != 1) begin fails++; $display("FAIL clamp_pulse got %0d want 1", valid_cycles); end
        tests++; if (cap_data !== 8'hC3) begin fails++; $display("FAIL clamp_data got %h want c3", cap_data); end
        divisor_buffer = 16'd9;
        idle(5);
    endtask

    task automatic test_config_latch();
        logic [15:0] rest;
        clear_mon();
        send_raw(16'h0000, 1, 10);
        divisor_buffer = 16'd3;
        parity_en = 1'b1;
        rest = 16'hFF69;
        send_raw(rest, 9, 10);
        idle(10);
        tests++; if (valid_cycles != 1) begin fails++; $display("FAIL latch_pulse got %0d want 1", valid_cycles); end
        tests++; if (cap_data !== 8'h69) begin fails++; $display("FAIL latch_data got %h want 69", cap_data); end
        tests++; if (cap_perr !== 1'b0) begin fails++; $display("FAIL latch_perr got %b want 0", cap_perr); end
        divisor_buffer = 16'd9;
        parity_en = 1'b0;
        idle(5);
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] f55;
        rx_ready = 1'b0;
        send_frame(8'h66, 1'b0, 1'b0, 1'b1, 10);
        send_frame(8'h77, 1'b0, 1'b0, 1'b1, 10);
        idle(5);
        tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pre_valid got %b want 1", rx_valid); end
        f55 = 16'hFEAA;
        send_raw(f55, 5, 10);
        #2;
        rst = 1'b0;
        rxd = 1'b1;
        #1;
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b want 0", rx_valid); end
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL rstmid_data got %h want 00", rx_data); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rstmid_overrun got %b want 0", overrun); end
        tests++; if (frame_err !== 1'b0 || parity_err !== 1'b0) begin fails++; $display("FAIL rstmid_errs got %b%b want 00", frame_err, parity_err); end
        @(negedge clk);
        rst = 1'b1;
        rx_ready = 1'b1;
        idle(10);
        clear_mon();
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 10);
        idle(10);
        tests++; if (valid_cycles != 1) begin fails++; $display("FAIL rstmid_next_pulse got %0d want 1", valid_cycles); end
        tests++; if (cap_data !== 8'h81) begin fails++; $display("FAIL rstmid_next_data got %h want 81", cap_data); end
        tests++; if (cap_ferr !== 1'b0) begin fails++; $display("FAIL rstmid_next_ferr got %b want 0", cap_ferr); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_back_to_back_overrun();
        test_glitch();
        test_clamp();
        test_config_latch();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
